// File: rtl/tanh_unit_scheduler.sv
// tanh_unit_scheduler: round-robin sharing of one combinational tanh unit among N_REQ requesters,
// with a registered operand stage (S1) and a backpressured result stage (S2).
module tanh_unit_scheduler #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_z,
   output logic [N_REQ-1:0]     req_ready,
   output logic [7:0]           func_z,
   input  logic [7:0]           func_a,
   output logic                 out_valid,
   output logic [7:0]           out_a,
   output logic [ID_W-1:0]      out_id,
   input  logic                 out_ready,
   output logic                 busy
);
   logic            op_valid;
   logic [7:0]      op_z;
   logic [ID_W-1:0] op_id;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] gnt;
   logic [ID_W:0]   idx;
   logic            s1_load, s2_load, acc;
   logic [7:0]      sel_z;

   assign s2_load   = !out_valid || out_ready;
   assign s1_load   = !op_valid || s2_load;
   // Gating with rst keeps req_ready low while reset is held, even though S1 looks empty.
   assign acc       = rst && s1_load && (|req_valid);
   assign req_ready = acc ? N_REQ'(1) << gnt : '0;
   assign sel_z     = req_z[{gnt, 3'b000} +: 8];
   assign func_z    = op_z;
   assign busy      = op_valid | out_valid;

   // Walk from farthest to nearest so the nearest valid index after rr_ptr wins.
   always_comb begin
      gnt = rr_ptr;
      idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         idx = (idx >= (ID_W+1)'(N_REQ)) ? idx - (ID_W+1)'(N_REQ) : idx;
         if (req_valid[idx[ID_W-1:0]]) gnt = idx[ID_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_valid  <= 1'b0;
         op_z      <= '0;
         op_id     <= '0;
         out_valid <= 1'b0;
         out_a     <= '0;
         out_id    <= '0;
         rr_ptr    <= ID_W'(N_REQ-1);
      end else begin
         if (s2_load) begin
            out_valid <= op_valid;
            if (op_valid) begin
               out_a  <= func_a;
               out_id <= op_id;
            end
         end
         if (s1_load) begin
            op_valid <= acc;
            if (acc) begin
               op_z   <= sel_z;
               op_id  <= gnt;
               rr_ptr <= gnt;
            end
         end
      end
   end
endmodule

// File: tb/tb_tanh_unit_scheduler.sv
// tb_tanh_unit_scheduler: table-driven plus hand-written sequences; the tanh unit is stubbed as ~func_z.
module tb_tanh_unit_scheduler;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_z;
   logic [3:0]  req_ready;
   logic [7:0]  func_z, func_a, out_a;
   logic        out_valid, out_ready, busy;
   logic [1:0]  out_id;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;
   assign func_a = ~func_z;

   tanh_unit_scheduler #(.N_REQ(4), .ID_W(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_z(req_z), .req_ready(req_ready),
      .func_z(func_z), .func_a(func_a), .out_valid(out_valid), .out_a(out_a),
      .out_id(out_id), .out_ready(out_ready), .busy(busy)
   );

   typedef struct {
      logic        rst_n;
      logic [3:0]  rv;
      logic [31:0] z;
      logic        ordy;
      logic [3:0]  rdy;
      logic        ov;
      logic [7:0]  a;
      logic [1:0]  id;
      logic        bsy;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          acc;
      logic [3:0]  wrap_rdy[4];
      logic [1:0]  wrap_id[4];
      rst = 1'b0; req_valid = '0; req_z = '0; out_ready = 1'b1;
      //           rst   rv       z             ordy  rdy      ov    a       id     bsy
      tbl[0]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[1]  = '{1'b1, 4'b0100, 32'h00370000, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[2]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
      tbl[3]  = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'hC8, 2'd2, 1'b1};
      tbl[4]  = '{1'b0, 4'b1111, 32'h40302010, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[5]  = '{1'b1, 4'b1111, 32'h40302010, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[6]  = '{1'b1, 4'b1111, 32'h40302010, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b1};
      tbl[7]  = '{1'b1, 4'b1111, 32'h40302010, 1'b1, 4'b0100, 1'b1, 8'hEF, 2'd0, 1'b1};
      tbl[8]  = '{1'b1, 4'b1111, 32'h40302010, 1'b1, 4'b1000, 1'b1, 8'hDF, 2'd1, 1'b1};
      tbl[9]  = '{1'b1, 4'b1111, 32'h40302010, 1'b1, 4'b0001, 1'b1, 8'hCF, 2'd2, 1'b1};
      tbl[10] = '{1'b1, 4'b0000, 32'h40302010, 1'b1, 4'b0000, 1'b1, 8'hBF, 2'd3, 1'b1};
      tbl[11] = '{1'b1, 4'b0000, 32'h40302010, 1'b1, 4'b0000, 1'b1, 8'hEF, 2'd0, 1'b1};
      tbl[12] = '{1'b1, 4'b0000, 32'h40302010, 1'b1, 4'b0000, 1'b0, 8'hEF, 2'd0, 1'b0};
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 13; i++) begin
         rst = tbl[i].rst_n; req_valid = tbl[i].rv; req_z = tbl[i].z; out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
         chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
         chk($sformatf("row%0d_a", i), 32'(out_a), 32'(tbl[i].a));
         chk($sformatf("row%0d_id", i), 32'(out_id), 32'(tbl[i].id));
         chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
         step();
      end

      // Backpressure: rr_ptr=0, so requester 1 goes first, then 0, then S1 and S2 stall.
      req_valid = 4'b0011; req_z = 32'h00002010; out_ready = 1'b0; acc = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         acc += $countones(req_ready);
         if (i == 0) chk("bp_ready0", 32'(req_ready), 32'h2);
         if (i == 1) chk("bp_ready1", 32'(req_ready), 32'h1);
         if (i >= 2) begin
            chk("bp_ready_full", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_a_hold", 32'(out_a), 32'hDF);
            chk("bp_id_hold", 32'(out_id), 32'h1);
         end
         step();
      end
      chk("bp_accepts", 32'(acc), 32'd2);
      out_ready = 1'b1;
      #1;
      chk("bp_rel_ready", 32'(req_ready), 32'h2);
      chk("bp_drain0_a", 32'(out_a), 32'hDF);
      chk("bp_drain0_id", 32'(out_id), 32'h1);
      step();
      req_valid = '0;
      #1;
      chk("bp_drain1_valid", 32'(out_valid), 32'h1);
      chk("bp_drain1_a", 32'(out_a), 32'hEF);
      chk("bp_drain1_id", 32'(out_id), 32'h0);
      step();
      #1;
      chk("bp_drain2_a", 32'(out_a), 32'hDF);
      chk("bp_drain2_id", 32'(out_id), 32'h1);
      step();
      #1;
      chk("bp_empty_valid", 32'(out_valid), 32'h0);
      chk("bp_empty_busy", 32'(busy), 32'h0);

      // Wrap-around: park rr_ptr at 3, then requesters 1 and 3 alternate.
      req_valid = 4'b1000; req_z = 32'h80002010;
      #1;
      chk("wrap_park", 32'(req_ready), 32'h8);
      step();
      wrap_rdy = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      wrap_id  = '{2'd0, 2'd3, 2'd1, 2'd3};
      req_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("wrap_ready%0d", i), 32'(req_ready), 32'(wrap_rdy[i]));
         if (i >= 1) chk($sformatf("wrap_id%0d", i), 32'(out_id), 32'(wrap_id[i]));
         step();
      end
      req_valid = '0;
      repeat (3) step();

      // Reset with both stages full.
      out_ready = 1'b0; req_valid = 4'b0001; req_z = 32'h00000055;
      step();
      step();
      #1;
      chk("rst_pre_valid", 32'(out_valid), 32'h1);
      chk("rst_pre_busy", 32'(busy), 32'h1);
      rst = 1'b0; req_valid = 4'b0011;
      #1;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h0);
      step();
      rst = 1'b1; out_ready = 1'b1; req_valid = 4'b0110; req_z = 32'h00664455;
      #1;
      chk("rst_first_grant", 32'(req_ready), 32'h2);
      chk("rst_no_stale0", 32'(out_valid), 32'h0);
      step();
      req_valid = '0;
      #1;
      chk("rst_no_stale1", 32'(out_valid), 32'h0);
      step();
      #1;
      chk("rst_new_valid", 32'(out_valid), 32'h1);
      chk("rst_new_a", 32'(out_a), 32'hBB);
      chk("rst_new_id", 32'(out_id), 32'h1);
      step();

      // Idle: operand register holds the last accepted z, rr_ptr stays at 1.
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("idle_busy", 32'(busy), 32'h0);
         chk("idle_valid", 32'(out_valid), 32'h0);
         chk("idle_func_z", 32'(func_z), 32'h44);
         step();
      end
      req_valid = 4'b0110;
      #1;
      chk("idle_rr_kept", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
